// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, instruction field positions, hazard FSM
// state encoding and the in-flight scoreboard entry type.
package dlx_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_NOP   = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 21;
    localparam int RS2_MSB = 20;
    localparam int RS2_LSB = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_LINK = 5'd31;

    typedef logic [1:0] hz_state_t;
    localparam hz_state_t ST_RUN   = 2'd0;
    localparam hz_state_t ST_HAZ   = 2'd1;
    localparam hz_state_t ST_MWAIT = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_mem;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = 7'd0;

    // True when a scoreboard entry will write the given source register.
    function automatic logic sb_match(input sb_entry_t entry, input logic [4:0] src);
        return entry.valid && (entry.dest == src);
    endfunction

endpackage

// File: rtl/dlx_reg_decode.sv
// Register-usage decode of the instruction in ID: which registers are read,
// which one is written, and whether it is a data-memory access.
import dlx_pkg::*;

module dlx_reg_decode (
    input  logic [31:0] i_ir,
    output logic [4:0]  o_src1,
    output logic        o_src1_vld,
    output logic [4:0]  o_src2,
    output logic        o_src2_vld,
    output logic [4:0]  o_dest,
    output logic        o_dest_vld,
    output logic        o_is_mem
);

    logic [5:0] w_opcode;
    logic       w_unused_bits;

    assign w_opcode      = i_ir[OPC_MSB:OPC_LSB];
    assign o_src1        = i_ir[RS1_MSB:RS1_LSB];
    assign o_src2        = i_ir[RS2_MSB:RS2_LSB];
    assign w_unused_bits = ^i_ir[RD_LSB-1:0];

    // Unlisted opcodes are treated as I-type (one source, dest in [20:16]).
    always_comb begin
        o_src1_vld = 1'b0;
        o_src2_vld = 1'b0;
        o_dest     = REG_ZERO;
        o_dest_vld = 1'b0;
        o_is_mem   = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                o_src1_vld = 1'b1;
                o_src2_vld = 1'b1;
                o_dest     = i_ir[RD_MSB:RD_LSB];
                o_dest_vld = 1'b1;
            end
            OP_SW: begin
                o_src1_vld = 1'b1;
                o_src2_vld = 1'b1;
                o_is_mem   = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                o_src1_vld = 1'b1;
            end
            OP_J, OP_NOP: begin
                o_is_mem = 1'b0;
            end
            OP_JAL: begin
                o_dest     = REG_LINK;
                o_dest_vld = 1'b1;
            end
            OP_LW: begin
                o_src1_vld = 1'b1;
                o_dest     = i_ir[RS2_MSB:RS2_LSB];
                o_dest_vld = 1'b1;
                o_is_mem   = 1'b1;
            end
            default: begin
                o_src1_vld = 1'b1;
                o_dest     = i_ir[RS2_MSB:RS2_LSB];
                o_dest_vld = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// DLX pipeline hazard control: RAW stalls against EX/MEM, branch flush and
// data-memory wait, with a saturating stall-cycle counter.
import dlx_pkg::*;

module dlx_hazard_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] IR_IN,
    input  logic        BRANCH_TAKEN,
    input  logic        MEM_READY,
    output logic        PC_LATCH_EN,
    output logic        IR_LATCH_EN,
    output logic        PIPE_EN,
    output logic        BUBBLE,
    output logic        FLUSH,
    output logic [15:0] STALL_COUNT
);

    logic [4:0] w_src1;
    logic       w_src1_vld;
    logic [4:0] w_src2;
    logic       w_src2_vld;
    logic [4:0] w_dest;
    logic       w_dest_vld;
    logic       w_is_mem;
    logic       w_src1_haz;
    logic       w_src2_haz;
    logic       w_raw;
    logic       w_mwait;
    logic       w_flush;
    hz_state_t  w_state;
    sb_entry_t  w_sb_next_ex;
    sb_entry_t  r_sb_ex;
    sb_entry_t  r_sb_mem;
    logic [15:0] r_stall_cnt;

    dlx_reg_decode u_decode (
        .i_ir       (IR_IN),
        .o_src1     (w_src1),
        .o_src1_vld (w_src1_vld),
        .o_src2     (w_src2),
        .o_src2_vld (w_src2_vld),
        .o_dest     (w_dest),
        .o_dest_vld (w_dest_vld),
        .o_is_mem   (w_is_mem)
    );

    // WB is deliberately absent: the register file writes in the first half-cycle.
    assign w_src1_haz = w_src1_vld && (w_src1 != REG_ZERO) &&
                        (sb_match(r_sb_ex, w_src1) || sb_match(r_sb_mem, w_src1));
    assign w_src2_haz = w_src2_vld && (w_src2 != REG_ZERO) &&
                        (sb_match(r_sb_ex, w_src2) || sb_match(r_sb_mem, w_src2));
    assign w_raw      = w_src1_haz || w_src2_haz;
    assign w_mwait    = r_sb_mem.is_mem && !MEM_READY;

    // Current control mode: memory wait beats branch flush beats RAW stall.
    always_comb begin
        if (w_mwait) begin
            w_state = ST_MWAIT;
        end else if (w_raw && !BRANCH_TAKEN) begin
            w_state = ST_HAZ;
        end else begin
            w_state = ST_RUN;
        end
    end

    assign w_flush = BRANCH_TAKEN && (w_state == ST_RUN);

    // Latch enables and bubble/flush controls; everything low while in reset.
    always_comb begin
        PC_LATCH_EN = 1'b0;
        IR_LATCH_EN = 1'b0;
        PIPE_EN     = 1'b0;
        BUBBLE      = 1'b0;
        FLUSH       = 1'b0;
        if (!Rst) begin
            PIPE_EN = 1'b0;
        end else begin
            case (w_state)
                ST_RUN: begin
                    PC_LATCH_EN = 1'b1;
                    IR_LATCH_EN = 1'b1;
                    PIPE_EN     = 1'b1;
                    BUBBLE      = w_flush;
                    FLUSH       = w_flush;
                end
                ST_HAZ: begin
                    PIPE_EN = 1'b1;
                    BUBBLE  = 1'b1;
                end
                ST_MWAIT: begin
                    PIPE_EN = 1'b0;
                end
                default: begin
                    PIPE_EN = 1'b0;
                end
            endcase
        end
    end

    // Entry entering EX; a write to r0 is recorded as no write at all.
    always_comb begin
        w_sb_next_ex = SB_EMPTY;
        if ((w_state == ST_RUN) && !w_flush) begin
            w_sb_next_ex.valid  = w_dest_vld && (w_dest != REG_ZERO);
            w_sb_next_ex.dest   = w_dest;
            w_sb_next_ex.is_mem = w_is_mem;
        end else begin
            w_sb_next_ex = SB_EMPTY;
        end
    end

    // Scoreboard shifts EX->MEM whenever the pipeline advances.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sb_ex  <= SB_EMPTY;
            r_sb_mem <= SB_EMPTY;
        end else if (PIPE_EN) begin
            r_sb_mem <= r_sb_ex;
            r_sb_ex  <= w_sb_next_ex;
        end else begin
            r_sb_mem <= r_sb_mem;
            r_sb_ex  <= r_sb_ex;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stall_cnt <= 16'd0;
        end else if (((w_state == ST_HAZ) || (w_state == ST_MWAIT)) &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign STALL_COUNT = r_stall_cnt;

endmodule
